// File: rtl/fpu_inflight_tracker_pkg.sv
// fpu_inflight_tracker_pkg: shared FPU pipeline sizes and per-op issue latencies
package fpu_inflight_tracker_pkg;
    localparam int FPU_DEPTH = 5;
    localparam int FP_REG_W  = 5;
    localparam int FPU_LAT_W = 3;
    typedef enum logic [2:0] {OP_FADD, OP_FSUB, OP_FMUL, OP_FDIV, OP_FMV} fpu_op_e;
    localparam logic [FPU_LAT_W-1:0] LAT_FADD = 3'd3;
    localparam logic [FPU_LAT_W-1:0] LAT_FSUB = 3'd3;
    localparam logic [FPU_LAT_W-1:0] LAT_FMUL = 3'd2;
    localparam logic [FPU_LAT_W-1:0] LAT_FDIV = 3'd5;
    localparam logic [FPU_LAT_W-1:0] LAT_MOVE = 3'd0;
    function automatic logic [FPU_LAT_W-1:0] op_lat(input fpu_op_e op);
        return op == OP_FADD ? LAT_FADD : op == OP_FSUB ? LAT_FSUB :
               op == OP_FMUL ? LAT_FMUL : op == OP_FDIV ? LAT_FDIV : LAT_MOVE;
    endfunction
endpackage

// File: rtl/fpu_inflight_tracker_if.sv
// fpu_inflight_tracker_if: issue/flush inputs and per-stage hazard outputs of the tracker
interface fpu_inflight_tracker_if
    import fpu_inflight_tracker_pkg::*;
#(
    parameter int DEPTH = FPU_DEPTH,
    parameter int REG_W = FP_REG_W,
    parameter int LAT_W = FPU_LAT_W
);
    logic                   stall;
    logic                   issue_valid;
    logic [REG_W-1:0]       issue_rd;
    logic                   issue_regwrite;
    logic [LAT_W-1:0]       issue_lat;
    logic                   kill_issue;
    logic [DEPTH-1:0]       flush_mask;
    logic [DEPTH*REG_W-1:0] stage_rd;
    logic [DEPTH-1:0]       stage_regwrite;
    logic [DEPTH-1:0]       stage_legal;
    logic [DEPTH-1:0]       stage_hazard;
    logic                   busy;
    logic                   wb_valid;
    logic [REG_W-1:0]       wb_rd;
    modport master (
        output stall, issue_valid, issue_rd, issue_regwrite, issue_lat, kill_issue, flush_mask,
        input  stage_rd, stage_regwrite, stage_legal, stage_hazard, busy, wb_valid, wb_rd
    );
    modport slave (
        input  stall, issue_valid, issue_rd, issue_regwrite, issue_lat, kill_issue, flush_mask,
        output stage_rd, stage_regwrite, stage_legal, stage_hazard, busy, wb_valid, wb_rd
    );
endinterface

// File: rtl/fpu_inflight_tracker_entry.sv
// fpu_inflight_entry: one pipeline stage slot with hold/advance/flush and saturating latency countdown
module fpu_inflight_entry #(
    parameter int REG_W = 5,
    parameter int LAT_W = 3,
    parameter bit DEC   = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_legal,
    input  logic             in_regwrite,
    input  logic [REG_W-1:0] in_rd,
    input  logic [LAT_W-1:0] in_remaining,
    output logic             legal,
    output logic             regwrite,
    output logic [REG_W-1:0] rd,
    output logic [LAT_W-1:0] remaining
);
    logic [LAT_W-1:0] next_remaining;
    assign next_remaining = (DEC && in_remaining != '0) ? in_remaining - LAT_W'(1) : in_remaining;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            legal     <= 1'b0;
            regwrite  <= 1'b0;
            rd        <= '0;
            remaining <= '0;
        end else if (stall) begin
            legal <= legal & ~flush;
        end else begin
            legal     <= in_legal;
            regwrite  <= in_regwrite;
            rd        <= in_rd;
            remaining <= next_remaining;
        end
    end
endmodule

// File: rtl/fpu_inflight_tracker.sv
// fpu_inflight_tracker: tracks in-flight FPU ops per stage for the decode hazard check and retire writeback
module fpu_inflight_tracker
    import fpu_inflight_tracker_pkg::*;
#(
    parameter int DEPTH = FPU_DEPTH,
    parameter int REG_W = FP_REG_W,
    parameter int LAT_W = FPU_LAT_W
) (
    input logic clk,
    input logic rstn,
    fpu_inflight_tracker_if.slave bus
);
    logic             legal    [DEPTH];
    logic             regwrite [DEPTH];
    logic [REG_W-1:0] rd       [DEPTH];
    logic [LAT_W-1:0] remaining[DEPTH];
    logic             in_legal    [DEPTH];
    logic             in_regwrite [DEPTH];
    logic [REG_W-1:0] in_rd       [DEPTH];
    logic [LAT_W-1:0] in_remaining[DEPTH];
    logic             new_legal;
    logic [LAT_W-1:0] new_lat;
    assign new_legal = bus.issue_valid & ~bus.kill_issue;
    assign new_lat   = bus.issue_lat > LAT_W'(DEPTH) ? LAT_W'(DEPTH) : bus.issue_lat;
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            // a rejected issue enters as an all-zero bubble
            assign in_legal[i]     = new_legal;
            assign in_regwrite[i]  = new_legal & bus.issue_regwrite;
            assign in_rd[i]        = new_legal ? bus.issue_rd : '0;
            assign in_remaining[i] = new_legal ? new_lat : '0;
        end else begin : g_body
            assign in_legal[i]     = legal[i-1] & ~bus.flush_mask[i-1];
            assign in_regwrite[i]  = regwrite[i-1];
            assign in_rd[i]        = rd[i-1];
            assign in_remaining[i] = remaining[i-1];
        end
        fpu_inflight_entry #(.REG_W(REG_W), .LAT_W(LAT_W), .DEC(i != 0)) u_entry (
            .clk         (clk),
            .rstn        (rstn),
            .stall       (bus.stall),
            .flush       (bus.flush_mask[i]),
            .in_legal    (in_legal[i]),
            .in_regwrite (in_regwrite[i]),
            .in_rd       (in_rd[i]),
            .in_remaining(in_remaining[i]),
            .legal       (legal[i]),
            .regwrite    (regwrite[i]),
            .rd          (rd[i]),
            .remaining   (remaining[i])
        );
        assign bus.stage_rd[i*REG_W +: REG_W] = rd[i];
        assign bus.stage_regwrite[i]          = regwrite[i];
        assign bus.stage_legal[i]             = legal[i];
        assign bus.stage_hazard[i]            = legal[i] & (remaining[i] != '0);
    end
    assign bus.busy     = |bus.stage_hazard;
    assign bus.wb_valid = legal[DEPTH-1] & regwrite[DEPTH-1] & ~bus.stall & ~bus.flush_mask[DEPTH-1];
    assign bus.wb_rd    = rd[DEPTH-1];
endmodule

// File: tb/tb_fpu_inflight_tracker.sv
// tb_fpu_inflight_tracker: vector table, corner sequences and random run against a stage/latency model
module tb_fpu_inflight_tracker;
    import fpu_inflight_tracker_pkg::*;
    localparam int D  = FPU_DEPTH;
    localparam int RW = FP_REG_W;
    localparam int LW = FPU_LAT_W;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    fpu_inflight_tracker_if #(.DEPTH(D), .REG_W(RW), .LAT_W(LW)) bus ();
    fpu_inflight_tracker #(.DEPTH(D), .REG_W(RW), .LAT_W(LW)) dut (.clk(clk), .rstn(rstn), .bus(bus));
    typedef struct {
        logic          legal;
        logic [RW-1:0] rd;
        logic          rw;
        int            lat;
    } ent_t;
    typedef struct {
        logic          v;
        logic [RW-1:0] rd;
        logic [LW-1:0] lat;
        logic [D-1:0]  legal;
        logic [D-1:0]  hz;
        logic          wb;
        logic [RW-1:0] wbrd;
    } vec_t;
    ent_t  m[D];
    vec_t  vt[7];
    int    checks = 0;
    int    failures = 0;
    bit    model_ok = 1'b0;
    string phase = "reset";

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // stage k of an entry issued with clamped latency L is still hazardous while k < L
    task automatic check_model();
        logic [D*RW-1:0] e_rd;
        logic [D-1:0]    e_rw, e_lg, e_hz;
        logic            e_wb;
        for (int k = 0; k < D; k++) begin
            e_rd[k*RW +: RW] = m[k].rd;
            e_rw[k] = m[k].rw;
            e_lg[k] = m[k].legal;
            e_hz[k] = m[k].legal && (k < m[k].lat);
        end
        e_wb = m[D-1].legal & m[D-1].rw & ~bus.stall & ~bus.flush_mask[D-1];
        chk({phase, ".stage_rd"}, 64'(bus.stage_rd), 64'(e_rd));
        chk({phase, ".stage_regwrite"}, 64'(bus.stage_regwrite), 64'(e_rw));
        chk({phase, ".stage_legal"}, 64'(bus.stage_legal), 64'(e_lg));
        chk({phase, ".stage_hazard"}, 64'(bus.stage_hazard), 64'(e_hz));
        chk({phase, ".busy"}, 64'(bus.busy), 64'(|e_hz));
        chk({phase, ".wb_valid"}, 64'(bus.wb_valid), 64'(e_wb));
        chk({phase, ".wb_rd"}, 64'(bus.wb_rd), 64'(m[D-1].rd));
    endtask

    task automatic model_edge();
        if (!rstn) begin
            for (int k = 0; k < D; k++) m[k] = '{1'b0, '0, 1'b0, 0};
        end else if (bus.stall) begin
            for (int k = 0; k < D; k++) if (bus.flush_mask[k]) m[k].legal = 1'b0;
        end else begin
            for (int k = D - 1; k > 0; k--) begin
                m[k] = m[k-1];
                m[k].legal = m[k-1].legal & ~bus.flush_mask[k-1];
            end
            if (bus.issue_valid && !bus.kill_issue)
                m[0] = '{1'b1, bus.issue_rd, bus.issue_regwrite, (int'(bus.issue_lat) > D) ? D : int'(bus.issue_lat)};
            else
                m[0] = '{1'b0, '0, 1'b0, 0};
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic v, input logic [RW-1:0] rd,
                         input logic rw, input logic [LW-1:0] lat, input logic k, input logic [D-1:0] fl);
        rstn = r;
        bus.stall = s;
        bus.issue_valid = v;
        bus.issue_rd = rd;
        bus.issue_regwrite = rw;
        bus.issue_lat = lat;
        bus.kill_issue = k;
        bus.flush_mask = fl;
        #1;
        if (model_ok) check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        if (!rstn) model_ok = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1, 0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic issue(input logic [RW-1:0] rd, input logic [LW-1:0] lat);
        drive(1, 0, 1, rd, 1, lat, 0, '0);
    endtask

    initial begin
        int n, wbs;
        logic [RW-1:0] last_rd;
        bit got;
        vt[0] = '{1'b1, 5'd7, op_lat(OP_FADD), 5'b00000, 5'b00000, 1'b0, 5'd0};
        vt[1] = '{1'b0, 5'd0, 3'd0, 5'b00001, 5'b00001, 1'b0, 5'd0};
        vt[2] = '{1'b0, 5'd0, 3'd0, 5'b00010, 5'b00010, 1'b0, 5'd0};
        vt[3] = '{1'b0, 5'd0, 3'd0, 5'b00100, 5'b00100, 1'b0, 5'd0};
        vt[4] = '{1'b0, 5'd0, 3'd0, 5'b01000, 5'b00000, 1'b0, 5'd0};
        vt[5] = '{1'b0, 5'd0, 3'd0, 5'b10000, 5'b00000, 1'b1, 5'd7};
        vt[6] = '{1'b0, 5'd0, 3'd0, 5'b00000, 5'b00000, 1'b0, 5'd0};

        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 5'd9, 1, 3'd3, 0, '0);
            tick();
        end
        phase = "after_reset";
        idle();
        chk("reset.stage_legal", 64'(bus.stage_legal), 64'd0);
        chk("reset.stage_hazard", 64'(bus.stage_hazard), 64'd0);
        chk("reset.stage_rd", 64'(bus.stage_rd), 64'd0);
        chk("reset.busy_wb", 64'({bus.busy, bus.wb_valid}), 64'd0);
        tick();

        phase = "table";
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, vt[i].v, vt[i].rd, vt[i].v, vt[i].lat, 0, '0);
            chk($sformatf("table[%0d].legal", i), 64'(bus.stage_legal), 64'(vt[i].legal));
            chk($sformatf("table[%0d].hazard", i), 64'(bus.stage_hazard), 64'(vt[i].hz));
            chk($sformatf("table[%0d].wb_valid", i), 64'(bus.wb_valid), 64'(vt[i].wb));
            chk($sformatf("table[%0d].wb_rd", i), 64'(bus.wb_rd), 64'(vt[i].wbrd));
            tick();
        end

        phase = "stall";
        issue(5'd7, op_lat(OP_FADD)); tick();
        idle(); tick();
        drive(1, 1, 1, 5'd12, 1, 3'd2, 0, '0); tick();
        drive(1, 1, 1, 5'd12, 1, 3'd2, 0, '0); tick();
        idle();
        chk("stall.hold_legal", 64'(bus.stage_legal), 64'b00010);
        chk("stall.hold_hazard", 64'(bus.stage_hazard), 64'b00010);
        n = 3;
        got = 1'b0;
        while (!got && n < 15) begin
            idle();
            n++;
            got = bus.wb_valid;
            if (got) chk("stall.wb_rd", 64'(bus.wb_rd), 64'd7);
            tick();
        end
        chk("stall.retire_cycle", 64'(n), 64'd7);
        for (int i = 0; i < 2; i++) begin idle(); tick(); end

        phase = "flush";
        issue(5'd3, op_lat(OP_FMUL)); tick();
        issue(5'd4, op_lat(OP_FMUL)); tick();
        drive(1, 0, 0, '0, 0, '0, 0, 5'b00001); tick();
        idle();
        chk("flush.legal", 64'(bus.stage_legal), 64'b00100);
        tick();
        wbs = 0;
        last_rd = '0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (bus.wb_valid) begin wbs++; last_rd = bus.wb_rd; end
            tick();
        end
        chk("flush.wb_count", 64'(wbs), 64'd1);
        chk("flush.wb_rd", 64'(last_rd), 64'd3);

        phase = "kill_clamp";
        drive(1, 0, 1, 5'd9, 1, op_lat(OP_FDIV), 1, '0); tick();
        idle();
        chk("kill.legal", 64'(bus.stage_legal), 64'd0);
        tick();
        issue(5'd10, 3'd7); tick();
        for (int i = 0; i < 4; i++) begin idle(); tick(); end
        idle();
        chk("clamp.hazard_stage4", 64'(bus.stage_hazard), 64'b10000);
        tick();
        idle(); tick();

        phase = "reset_mid";
        issue(5'd1, op_lat(OP_FSUB)); tick();
        issue(5'd2, op_lat(OP_FMV)); tick();
        issue(5'd5, op_lat(OP_FDIV)); tick();
        drive(0, 0, 0, '0, 0, '0, 0, '0); tick();
        idle();
        chk("reset_mid.legal", 64'(bus.stage_legal), 64'd0);
        tick();
        wbs = 0;
        for (int i = 0; i < 6; i++) begin
            idle();
            if (bus.wb_valid) wbs++;
            tick();
        end
        chk("reset_mid.wb_count", 64'(wbs), 64'd0);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0, 1'($urandom),
                  RW'($urandom), 1'($urandom), LW'($urandom),
                  $urandom_range(0, 5) == 0, ($urandom_range(0, 4) == 0) ? D'($urandom) : '0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
